// File: rtl/cim_mem_arbiter_pkg.sv
// Shared constants and types for the CiM temporary-result storage arbiter.
// Source indices follow MEM_ACCESS_SRC_T. Each source owns one bit in every
// per-source request vector and one slice in every packed per-source table.
package cim_mem_arbiter_pkg;

  // Every unit that can reach the CiM temporary-result storage
  typedef enum logic [2:0] {
    MEM_SRC_BUS_FSM        = 3'd0,
    MEM_SRC_LOGIC_FSM      = 3'd1,
    MEM_SRC_DATA_FILL_FSM  = 3'd2,
    MEM_SRC_DENSE_BCST_FSM = 3'd3,
    MEM_SRC_MAC            = 3'd4,
    MEM_SRC_LAYERNORM      = 3'd5,
    MEM_SRC_SOFTMAX        = 3'd6
  } MEM_ACCESS_SRC_T;

  localparam int MEM_ACCESS_SRC_NUM        = 7;
  // Deliberately not a power of two, so the address bus can express
  // out-of-range addresses
  localparam int TEMP_RES_STORAGE_SIZE_CIM = 200;
  localparam int N_STORAGE                 = 16;

  // Storage read latency, counted from the registered enable to the sample
  localparam int CIM_MEM_RD_LAT   = 1;
  // Consecutive locked grants allowed before a burst is forcibly broken
  localparam int CIM_MEM_MAX_LOCK = 64;

endpackage

// File: rtl/cim_mem_arbiter_rr.sv
// rr_arbiter: combinational round-robin priority picker.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index that has the highest priority this cycle
//   grant - one-hot grant, or zero when nothing requests
//   idx   - binary index of the granted requester (0 when there is no grant)
//   any   - high when some requester was granted
module rr_arbiter #(
  parameter int N     = 7,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk the requesters from ptr upward, wrapping at N-1, and keep the first hit
  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cim_mem_arbiter.sv
// cim_mem_arbiter: shares the single-port CiM temporary-result storage among
// all memory-access sources. Each cycle it grants one read or write by
// round-robin arbitration. A source can lock the grant for a burst; a lock is
// forcibly released after MAX_LOCK consecutive locked grants. The memory
// command is registered, and read data returns with a one-hot rd_valid aimed
// at the source that issued the read.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   read_req_src/write_req_src - per-source read/write requests
//   lock_src                  - per-source burst lock request
//   addr_table, write_data    - packed per-source address / write data
//   grant                     - combinational one-hot grant for this cycle
//   rd_valid, rd_data         - read return to the requesting source
//   mem_en/we/addr/wdata      - registered storage command
//   mem_rdata                 - storage read data
//   err_rdwr, err_oob, err_lock_to - sticky error flags
module cim_mem_arbiter
  import cim_mem_arbiter_pkg::*;
#(
  parameter int N_SRC    = MEM_ACCESS_SRC_NUM,
  parameter int DEPTH    = TEMP_RES_STORAGE_SIZE_CIM,
  parameter int ADDR_W   = $clog2(TEMP_RES_STORAGE_SIZE_CIM),
  parameter int DATA_W   = N_STORAGE,
  parameter int RD_LAT   = CIM_MEM_RD_LAT,
  parameter int MAX_LOCK = CIM_MEM_MAX_LOCK
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         read_req_src,
  input  logic [N_SRC-1:0]         write_req_src,
  input  logic [N_SRC-1:0]         lock_src,
  input  logic [N_SRC*ADDR_W-1:0]  addr_table,
  input  logic [N_SRC*DATA_W-1:0]  write_data,
  output logic [N_SRC-1:0]         grant,
  output logic [N_SRC-1:0]         rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     err_rdwr,
  output logic                     err_oob,
  output logic                     err_lock_to
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  logic [N_SRC-1:0]  req;
  logic [IDX_W-1:0]  rr_ptr;
  logic [N_SRC-1:0]  rr_grant;
  logic [IDX_W-1:0]  rr_idx;
  logic              rr_any;

  logic              lock_valid;
  logic [IDX_W-1:0]  lock_owner;
  logic [CNT_W-1:0]  lock_cnt;
  logic              lock_mode;
  logic [CNT_W-1:0]  lock_cnt_inc;
  logic              lock_expire;

  logic [N_SRC-1:0]  grant_c;
  logic [IDX_W-1:0]  g_idx;
  logic              g_any;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              g_write;
  logic              g_read;
  logic              g_oob;
  logic              g_locked;
  logic [IDX_W-1:0]  rr_ptr_next;

  logic [RD_LAT-1:0]            tag_valid;
  logic [RD_LAT-1:0]            tag_oob;
  logic [RD_LAT-1:0][N_SRC-1:0] tag_src;

  assign req = read_req_src | write_req_src;

  rr_arbiter #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  // The lock owner keeps the grant only while it still requests and still
  // asserts lock; otherwise the round-robin picker decides.
  always_comb begin
    lock_mode = lock_valid && req[lock_owner] && lock_src[lock_owner];
    grant_c   = rr_grant;
    g_idx     = rr_idx;
    g_any     = rr_any;
    if (lock_mode) begin
      grant_c             = '0;
      grant_c[lock_owner] = 1'b1;
      g_idx               = lock_owner;
      g_any               = 1'b1;
    end
  end

  assign grant = grant_c;

  // Decode the granted source's operation. Write beats read when a source
  // raises both, so a conflicting source never gets a read return.
  always_comb begin
    g_addr       = addr_table[int'(g_idx)*ADDR_W +: ADDR_W];
    g_wdata      = write_data[int'(g_idx)*DATA_W +: DATA_W];
    g_write      = write_req_src[g_idx];
    g_read       = read_req_src[g_idx] & ~g_write;
    g_locked     = lock_src[g_idx];
    g_oob        = ({1'b0, g_addr} >= (ADDR_W+1)'(DEPTH));
    lock_cnt_inc = lock_mode ? (lock_cnt + CNT_W'(1)) : CNT_W'(1);
    lock_expire  = (int'(lock_cnt_inc) >= MAX_LOCK);
    rr_ptr_next  = (int'(g_idx) == N_SRC-1) ? '0 : (g_idx + IDX_W'(1));
  end

  // Arbitration state: the pointer moves past every granted source, including
  // locked grants, so a forced release resumes right after the owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      lock_valid  <= 1'b0;
      lock_owner  <= '0;
      lock_cnt    <= '0;
      err_lock_to <= 1'b0;
    end else begin
      if (g_any) rr_ptr <= rr_ptr_next;
      if (g_any && g_locked && !lock_expire) begin
        lock_valid <= 1'b1;
        lock_owner <= g_idx;
        lock_cnt   <= lock_cnt_inc;
      end else begin
        lock_valid <= 1'b0;
        lock_cnt   <= '0;
      end
      if (g_any && g_locked && lock_expire) err_lock_to <= 1'b1;
    end
  end

  // Command stage: out-of-range grants are issued but never reach the macro
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err_oob   <= 1'b0;
      err_rdwr  <= 1'b0;
    end else begin
      mem_en <= g_any & ~g_oob;
      if (g_any) begin
        mem_we    <= g_write;
        mem_addr  <= g_addr;
        mem_wdata <= g_wdata;
      end
      if (g_any && g_oob) err_oob <= 1'b1;
      if (|(read_req_src & write_req_src)) err_rdwr <= 1'b1;
    end
  end

  // Read tags travel alongside the command. An out-of-range read still returns
  // zero data so its requester does not wait forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid <= '0;
      tag_oob   <= '0;
      tag_src   <= '0;
      rd_valid  <= '0;
      rd_data   <= '0;
    end else begin
      tag_valid[0] <= g_any & g_read;
      tag_oob[0]   <= g_oob;
      tag_src[0]   <= grant_c;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_oob[k]   <= tag_oob[k-1];
        tag_src[k]   <= tag_src[k-1];
      end
      if (tag_valid[RD_LAT-1]) begin
        rd_valid <= tag_src[RD_LAT-1];
        rd_data  <= tag_oob[RD_LAT-1] ? '0 : mem_rdata;
      end else begin
        rd_valid <= '0;
        rd_data  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cim_mem_arbiter.sv
// Testbench for cim_mem_arbiter: a table of per-cycle vectors covering
// round-robin order, read latency, lock bursts and write-then-read, followed
// by hand-written sequences for out-of-range access, read/write conflict,
// lock timeout and reset during an in-flight read.
module tb_cim_mem_arbiter;
  import cim_mem_arbiter_pkg::*;

  localparam int N     = 7;
  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 200;

  localparam logic [6:0] BUS   = 7'b0000001;
  localparam logic [6:0] LOGIC = 7'b0000010;
  localparam logic [6:0] DFILL = 7'b0000100;
  localparam logic [6:0] DBS   = 7'b0001000;
  localparam logic [6:0] MAC   = 7'b0010000;
  localparam logic [6:0] LN    = 7'b0100000;
  localparam logic [6:0] SM    = 7'b1000000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    read_req_src  = '0;
  logic [N-1:0]    write_req_src = '0;
  logic [N-1:0]    lock_src      = '0;
  logic [N*AW-1:0] addr_table    = '0;
  logic [N*DW-1:0] write_data    = '0;
  logic [N-1:0]    grant;
  logic [N-1:0]    rd_valid;
  logic [DW-1:0]   rd_data;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            err_rdwr;
  logic            err_oob;
  logic            err_lock_to;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [DEPTH];

  cim_mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .read_req_src  (read_req_src),
    .write_req_src (write_req_src),
    .lock_src      (lock_src),
    .addr_table    (addr_table),
    .write_data    (write_data),
    .grant         (grant),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .err_rdwr      (err_rdwr),
    .err_oob       (err_oob),
    .err_lock_to   (err_lock_to)
  );

  always #5 clk = ~clk;

  // Storage stand-in: preloaded on reset with 0x1000+addr (addr 10 holds 0xAB),
  // written on the clock edge, read combinationally. Out-of-range reads return
  // a nonzero pattern so the arbiter's zero forcing is visible.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'h1000 + 16'(i);
      mem[10] <= 16'h00AB;
    end else if (mem_en && mem_we && int'(mem_addr) < DEPTH) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = (int'(mem_addr) < DEPTH) ? mem[mem_addr] : 16'hDEAD;

  typedef struct {
    logic [6:0]  rd;
    logic [6:0]  wr;
    logic [6:0]  lk;
    logic [7:0]  abase;
    logic [15:0] dbase;
    logic [6:0]  e_grant;
    logic        e_en;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [6:0]  e_rdv;
    logic [15:0] e_rdd;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(logic [6:0] rd, logic [6:0] wr, logic [6:0] lk,
                              logic [7:0] abase, logic [15:0] dbase,
                              logic [6:0] e_grant, logic e_en, logic e_we,
                              logic [7:0] e_addr, logic [6:0] e_rdv,
                              logic [15:0] e_rdd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.lk = lk; v.abase = abase; v.dbase = dbase;
    v.e_grant = e_grant; v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr;
    v.e_rdv = e_rdv; v.e_rdd = e_rdd;
    return v;
  endfunction

  // Drive one cycle of requests just after the clock edge. Source i gets
  // address abase+i and write data dbase+i.
  task automatic applyStimulus(input logic [6:0] rd, input logic [6:0] wr,
                               input logic [6:0] lk, input logic [7:0] abase,
                               input logic [15:0] dbase);
    @(posedge clk);
    #1;
    read_req_src  = rd;
    write_req_src = wr;
    lock_src      = lk;
    for (int i = 0; i < N; i++) begin
      addr_table[i*AW +: AW] = abase + 8'(i);
      write_data[i*DW +: DW] = dbase + 16'(i);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n6;
    bit  got_bus;

    // Round-robin writes, MAC read latency, LAYERNORM lock burst, write-then-read
    vecs[0]  = mk(0,    7'h7F, 0, 20, 16'h2000, BUS,   0, 0, 0,  0, 0);
    vecs[1]  = mk(0,    7'h7F, 0, 20, 16'h2000, LOGIC, 1, 1, 20, 0, 0);
    vecs[2]  = mk(0,    7'h7F, 0, 20, 16'h2000, DFILL, 1, 1, 21, 0, 0);
    vecs[3]  = mk(0,    7'h7F, 0, 20, 16'h2000, DBS,   1, 1, 22, 0, 0);
    vecs[4]  = mk(0,    7'h7F, 0, 20, 16'h2000, MAC,   1, 1, 23, 0, 0);
    vecs[5]  = mk(0,    7'h7F, 0, 20, 16'h2000, LN,    1, 1, 24, 0, 0);
    vecs[6]  = mk(0,    7'h7F, 0, 20, 16'h2000, SM,    1, 1, 25, 0, 0);
    vecs[7]  = mk(0,    7'h7F, 0, 20, 16'h2000, BUS,   1, 1, 26, 0, 0);
    vecs[8]  = mk(MAC,  0,     0, 6,  0,        MAC,   1, 1, 20, 0, 0);
    vecs[9]  = mk(0,    0,     0, 0,  0,        0,     1, 0, 10, 0, 0);
    vecs[10] = mk(0,    0,     0, 0,  0,        0,     0, 0, 0,  MAC, 16'h00AB);
    vecs[11] = mk(LN|MAC, 0,  LN, 0,  0,        LN,    0, 0, 0,  0, 0);
    vecs[12] = mk(LN|MAC, 0,  LN, 0,  0,        LN,    1, 0, 5,  0, 0);
    vecs[13] = mk(LN|MAC, 0,  LN, 0,  0,        LN,    1, 0, 5,  LN, 16'h1005);
    vecs[14] = mk(LN|MAC, 0,  LN, 0,  0,        LN,    1, 0, 5,  LN, 16'h1005);
    vecs[15] = mk(MAC,  0,     0, 0,  0,        MAC,   1, 0, 5,  LN, 16'h1005);
    vecs[16] = mk(0,    0,     0, 0,  0,        0,     1, 0, 4,  LN, 16'h1005);
    vecs[17] = mk(0,    0,     0, 0,  0,        0,     0, 0, 0,  MAC, 16'h1004);
    vecs[18] = mk(0,    DBS,   0, 30, 16'h3000, DBS,   0, 0, 0,  0, 0);
    vecs[19] = mk(DBS,  0,     0, 30, 16'h3000, DBS,   1, 1, 33, 0, 0);
    vecs[20] = mk(0,    0,     0, 0,  0,        0,     1, 0, 33, 0, 0);
    vecs[21] = mk(0,    0,     0, 0,  0,        0,     0, 0, 0,  DBS, 16'h3003);

    // Reset values
    @(negedge clk);
    checkOutput("reset_grant",    32'(grant),    0);
    checkOutput("reset_rd_valid", 32'(rd_valid), 0);
    checkOutput("reset_mem_en",   32'(mem_en),   0);
    checkOutput("reset_errs",     32'({err_rdwr, err_oob, err_lock_to}), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int v = 0; v < 22; v++) begin
      applyStimulus(vecs[v].rd, vecs[v].wr, vecs[v].lk, vecs[v].abase, vecs[v].dbase);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_grant", v), 32'(grant), 32'(vecs[v].e_grant));
      checkOutput($sformatf("vec%0d_mem_en", v), 32'(mem_en), 32'(vecs[v].e_en));
      if (vecs[v].e_en) begin
        checkOutput($sformatf("vec%0d_mem_we", v), 32'(mem_we), 32'(vecs[v].e_we));
        checkOutput($sformatf("vec%0d_mem_addr", v), 32'(mem_addr), 32'(vecs[v].e_addr));
        if (vecs[v].e_we)
          checkOutput($sformatf("vec%0d_mem_wdata", v), 32'(mem_wdata),
                      32'(16'h2000 + 16'(vecs[v].e_addr) - 16'd20 + ((vecs[v].e_addr >= 30) ? 16'h0FF6 : 16'h0)));
      end
      checkOutput($sformatf("vec%0d_rd_valid", v), 32'(rd_valid), 32'(vecs[v].e_rdv));
      if (vecs[v].e_rdv != 0)
        checkOutput($sformatf("vec%0d_rd_data", v), 32'(rd_data), 32'(vecs[v].e_rdd));
    end
    checkOutput("burst_err_lock_to", 32'(err_lock_to), 0);

    // Out-of-range read from DATA_FILL (address = DEPTH)
    applyStimulus(DFILL, 0, 0, 8'd198, 0);
    @(negedge clk);
    checkOutput("oob_err_before", 32'(err_oob), 0);
    checkOutput("oob_grant", 32'(grant), 32'(DFILL));
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("oob_mem_en", 32'(mem_en), 0);
    checkOutput("oob_err", 32'(err_oob), 1);
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("oob_rd_valid", 32'(rd_valid), 32'(DFILL));
    checkOutput("oob_rd_data", 32'(rd_data), 0);

    // LOGIC raises read and write together: the write wins
    applyStimulus(LOGIC, LOGIC, 0, 8'd40, 16'h4000);
    @(negedge clk);
    checkOutput("conflict_err_before", 32'(err_rdwr), 0);
    checkOutput("conflict_grant", 32'(grant), 32'(LOGIC));
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("conflict_mem_en", 32'(mem_en), 1);
    checkOutput("conflict_mem_we", 32'(mem_we), 1);
    checkOutput("conflict_mem_addr", 32'(mem_addr), 41);
    checkOutput("conflict_mem_wdata", 32'(mem_wdata), 32'h4001);
    checkOutput("conflict_err", 32'(err_rdwr), 1);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput($sformatf("conflict_no_rd_valid%0d", c), 32'(rd_valid), 0);
    end

    // SOFTMAX locks indefinitely while BUS_FSM waits
    n6 = 0;
    got_bus = 1'b0;
    applyStimulus(SM | BUS, 0, SM, 0, 0);
    for (int c = 0; c < 100 && !got_bus; c++) begin
      @(negedge clk);
      if (c == 0) checkOutput("timeout_err_before", 32'(err_lock_to), 0);
      if (grant == SM) n6++;
      else begin
        got_bus = 1'b1;
        checkOutput("timeout_next_grant", 32'(grant), 32'(BUS));
        checkOutput("timeout_err", 32'(err_lock_to), 1);
      end
    end
    checkOutput("timeout_bound", 32'(got_bus), 1);
    checkOutput("timeout_grant_count", 32'(n6), 64);
    for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 0, 0);

    // Reset while a MAC read command sits on the storage pins
    applyStimulus(MAC, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rstmid_grant", 32'(grant), 32'(MAC));
    applyStimulus(0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_rd_valid", 32'(rd_valid), 0);
    checkOutput("rstmid_mem_en", 32'(mem_en), 0);
    checkOutput("rstmid_mem_addr", 32'(mem_addr), 0);
    checkOutput("rstmid_mem_wdata", 32'(mem_wdata), 0);
    checkOutput("rstmid_errs", 32'({err_rdwr, err_oob, err_lock_to}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rstmid_no_rd_valid%0d", c), 32'(rd_valid), 0);
    end
    applyStimulus(SM | BUS, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rstmid_rr_restart", 32'(grant), 32'(BUS));
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
